// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID->EX stage that decodes a MIPS-I integer instruction and its GPR reads into ALU {aluc, a, b}.
// Latency: exactly one cycle from an accepted input to out_valid; a single registered slot, no bypass.
// Backpressure: in_ready = !out_valid | out_ready; while out_valid & !out_ready every out_* holds and no input is taken.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake for instr, rs_data, rt_data
//   instr, rs_data, rt_data  instruction word and GPR[rs] / GPR[rt] read data
//   flush                    drops the held result and any incoming instruction
//   out_valid / out_ready    output handshake toward the ALU/EX stage
//   out_aluc, out_a, out_b   ALU opcode and operands (a = shift amount for shifts)
//   out_rd, out_wen          destination register and writeback enable
//   out_ovf_trap             signed-overflow trap enable (add, sub, addi)
//   out_illegal              decoded word is not a supported opcode/funct
//   illegal_seen             sticky flag: an illegal instruction was accepted since reset
module alu_operand_stage #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instr,
  input  logic [DW-1:0]  rs_data,
  input  logic [DW-1:0]  rt_data,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3:0]     out_aluc,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [RAW-1:0] out_rd,
  output logic           out_wen,
  output logic           out_ovf_trap,
  output logic           out_illegal,
  output logic           illegal_seen
);

  // ALU opcode encoding
  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // One decoded instruction, the contents of the output slot
  typedef struct packed {
    logic [3:0]     aluc;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [RAW-1:0] rd;
    logic           wen;
    logic           ovf_trap;
    logic           illegal;
  } dec_t;

  logic [5:0]    op;
  logic [5:0]    fn;
  logic [15:0]   imm;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic [DW-1:0] shamt_imm;
  logic [DW-1:0] shamt_reg;
  logic          legal;
  dec_t          dec;
  dec_t          slot;
  logic          slot_vld;
  logic          seen;
  logic          accept;

  // The rs index field is not needed: the register file read already arrived on rs_data.
  logic rs_field_unused;
  assign rs_field_unused = ^instr[25:21];

  assign op        = instr[31:26];
  assign fn        = instr[5:0];
  assign imm       = instr[15:0];
  assign imm_sext  = {{(DW-16){imm[15]}}, imm};
  assign imm_zext  = {{(DW-16){1'b0}}, imm};
  assign shamt_imm = {{(DW-5){1'b0}}, instr[10:6]};
  // Variable shifts only honour the low five bits of GPR[rs].
  assign shamt_reg = {{(DW-5){1'b0}}, rs_data[4:0]};

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    if (op == OP_RTYPE) begin
      legal  = 1'b1;
      dec.a  = rs_data;
      dec.b  = rt_data;
      dec.rd = instr[15:11];
      case (fn)
        FN_ADD:  begin dec.aluc = ALU_ADD; dec.ovf_trap = 1'b1; end
        FN_ADDU: dec.aluc = ALU_ADDU;
        FN_SUB:  begin dec.aluc = ALU_SUB; dec.ovf_trap = 1'b1; end
        FN_SUBU: dec.aluc = ALU_SUBU;
        FN_AND:  dec.aluc = ALU_AND;
        FN_OR:   dec.aluc = ALU_OR;
        FN_XOR:  dec.aluc = ALU_XOR;
        FN_NOR:  dec.aluc = ALU_NOR;
        FN_SLT:  dec.aluc = ALU_SLT;
        FN_SLTU: dec.aluc = ALU_SLTU;
        FN_SLL:  begin dec.aluc = ALU_SLL; dec.a = shamt_imm; end
        FN_SRL:  begin dec.aluc = ALU_SRL; dec.a = shamt_imm; end
        FN_SRA:  begin dec.aluc = ALU_SRA; dec.a = shamt_imm; end
        FN_SLLV: begin dec.aluc = ALU_SLL; dec.a = shamt_reg; end
        FN_SRLV: begin dec.aluc = ALU_SRL; dec.a = shamt_reg; end
        FN_SRAV: begin dec.aluc = ALU_SRA; dec.a = shamt_reg; end
        default: legal = 1'b0;
      endcase
    end else begin
      legal  = 1'b1;
      dec.a  = rs_data;
      dec.rd = instr[20:16];
      case (op)
        OP_ADDI:  begin dec.aluc = ALU_ADD; dec.b = imm_sext; dec.ovf_trap = 1'b1; end
        OP_ADDIU: begin dec.aluc = ALU_ADDU; dec.b = imm_sext; end
        OP_SLTI:  begin dec.aluc = ALU_SLT;  dec.b = imm_sext; end
        OP_SLTIU: begin dec.aluc = ALU_SLTU; dec.b = imm_sext; end
        OP_ANDI:  begin dec.aluc = ALU_AND;  dec.b = imm_zext; end
        OP_ORI:   begin dec.aluc = ALU_OR;   dec.b = imm_zext; end
        OP_XORI:  begin dec.aluc = ALU_XOR;  dec.b = imm_zext; end
        // The ALU does the <<16 itself, so b carries the raw immediate.
        OP_LUI:   begin dec.aluc = ALU_LUI;  dec.a = '0; dec.b = imm_zext; end
        default:  legal = 1'b0;
      endcase
    end

    if (legal) begin
      dec.wen = (dec.rd != '0);
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !slot_vld || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= 1'b0;
      slot     <= '0;
      seen     <= 1'b0;
    end else if (flush) begin
      slot_vld <= 1'b0;
    end else if (accept) begin
      slot_vld <= 1'b1;
      slot     <= dec;
      seen     <= seen | dec.illegal;
    end else if (out_ready) begin
      // Drained with nothing behind it; payload is left as-is.
      slot_vld <= 1'b0;
    end
  end

  assign out_valid    = slot_vld;
  assign out_aluc     = slot.aluc;
  assign out_a        = slot.a;
  assign out_b        = slot.b;
  assign out_rd       = slot.rd;
  assign out_wen      = slot.wen;
  assign out_ovf_trap = slot.ovf_trap;
  assign out_illegal  = slot.illegal;
  assign illegal_seen = seen;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluc;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_ovf_trap;
  logic        out_illegal;
  logic        illegal_seen;

  alu_operand_stage #(.DW(32), .RAW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluc(out_aluc), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wen(out_wen), .out_ovf_trap(out_ovf_trap),
    .out_illegal(out_illegal), .illegal_seen(illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        ovf;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference tables: which opcodes/functs exist and their ALU code
  logic [3:0] r_tab [64];
  bit         r_ok  [64];
  logic [3:0] i_tab [64];
  bit         i_ok  [64];
  logic [5:0] r_list [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".aluc"}, 32'(out_aluc), 32'(e.aluc));
    chk({tag, ".a"}, out_a, e.a);
    chk({tag, ".b"}, out_b, e.b);
    if (!e.ill) chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
    chk({tag, ".wen"}, 32'(out_wen), 32'(e.wen));
    chk({tag, ".ovf"}, 32'(out_ovf_trap), 32'(e.ovf));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(e.ill));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, input logic fl);
    in_valid = v; instr = ins; rs_data = rs; rt_data = rt; out_ready = ordy; flush = fl;
  endtask

  task automatic init_tables();
    logic [5:0] rf [16];
    logic [3:0] ra [16];
    rf = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
           6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    ra = '{4'hE, 4'hD, 4'hC, 4'hE, 4'hD, 4'hC, 4'h2, 4'h0,
           4'h3, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hA};
    for (int k = 0; k < 64; k++) begin
      r_ok[k] = 0; i_ok[k] = 0; r_tab[k] = 0; i_tab[k] = 0;
    end
    for (int k = 0; k < 16; k++) begin
      r_ok[rf[k]] = 1; r_tab[rf[k]] = ra[k]; r_list[k] = rf[k];
    end
    i_ok[8'h08] = 1; i_tab[8'h08] = 4'h2;
    i_ok[8'h09] = 1; i_tab[8'h09] = 4'h0;
    i_ok[8'h0A] = 1; i_tab[8'h0A] = 4'hB;
    i_ok[8'h0B] = 1; i_tab[8'h0B] = 4'hA;
    i_ok[8'h0C] = 1; i_tab[8'h0C] = 4'h4;
    i_ok[8'h0D] = 1; i_tab[8'h0D] = 4'h5;
    i_ok[8'h0E] = 1; i_tab[8'h0E] = 4'h6;
    i_ok[8'h0F] = 1; i_tab[8'h0F] = 4'h8;
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int op, fn;
    logic [31:0] imm;
    e = '0;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    imm = 32'(ins[15:0]);
    if (op == 0 && r_ok[fn]) begin
      e.aluc = r_tab[fn];
      e.b = rt;
      e.rd = ins[15:11];
      if (fn < 4) e.a = 32'(ins[10:6]);      // shift by shamt field
      else if (fn < 8) e.a = rs % 32;        // shift by register
      else e.a = rs;
      e.ovf = (fn == 'h20 || fn == 'h22);
    end else if (op != 0 && i_ok[op]) begin
      e.aluc = i_tab[op];
      e.rd = ins[20:16];
      if (op == 'h0F) begin
        e.a = 0; e.b = imm;
      end else begin
        e.a = rs;
        if (op >= 'h0C) e.b = imm;
        else e.b = (imm >= 32'h8000) ? 32'hFFFF0000 + imm : imm;
      end
      e.ovf = (op == 'h08);
    end else begin
      e.ill = 1;
    end
    e.wen = !e.ill && (e.rd != 0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: w = {6'h00, w[25:6], r_list[$urandom_range(0, 15)]};
      2: w = {6'(8 + $urandom_range(0, 7)), w[25:0]};
      default: w = {6'h00, w[25:0]};
    endcase
    if ($urandom_range(0, 15) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 15) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  vec_t vecs [11];

  initial begin
    logic seen_exp;
    logic m_vld, m_seen, m_rdy, m_acc;
    exp_t m_rec, d;

    init_tables();
    vecs[0]  = '{32'h2023FFFF, 32'd5, 32'd0,          '{4'h2, 32'd5, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b1, 1'b0}};
    vecs[1]  = '{32'h3C0400AB, 32'd9, 32'd0,          '{4'h8, 32'd0, 32'h000000AB, 5'd4, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{32'h000510C0, 32'd0, 32'd1,          '{4'hE, 32'd3, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{32'h00000000, 32'd0, 32'd0,          '{4'hE, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{32'hFC000000, 32'd7, 32'd7,          '{4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1}};
    vecs[5]  = '{32'h01093822, 32'd10, 32'd3,         '{4'h3, 32'd10, 32'd3, 5'd7, 1'b1, 1'b1, 1'b0}};
    vecs[6]  = '{32'h00620807, 32'h25, 32'h80000000,  '{4'hC, 32'd5, 32'h80000000, 5'd1, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = '{32'h30C58001, 32'hFFFF0000, 32'd0,   '{4'h4, 32'hFFFF0000, 32'h00008001, 5'd5, 1'b1, 1'b0, 1'b0}};
    vecs[8]  = '{32'h2C20FFFE, 32'd1, 32'd0,          '{4'hA, 32'd1, 32'hFFFFFFFE, 5'd0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{32'h00000001, 32'd3, 32'd4,          '{4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1}};
    vecs[10] = '{32'h0000F821, 32'd7, 32'd9,          '{4'h0, 32'd7, 32'd9, 5'd31, 1'b1, 1'b0, 1'b0}};

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.illegal_seen", 32'(illegal_seen), 0);
    chk("rst.aluc", 32'(out_aluc), 0);
    chk("rst.a", out_a, 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Table of single instructions, streamed back to back
    seen_exp = 0;
    foreach (vecs[k]) begin
      drive(1, vecs[k].instr, vecs[k].rs, vecs[k].rt, 1, 0);
      tick();
      seen_exp = seen_exp | vecs[k].e.ill;
      chk($sformatf("vec%0d.valid", k), 32'(out_valid), 1);
      chk_out($sformatf("vec%0d", k), vecs[k].e);
      chk($sformatf("vec%0d.seen", k), 32'(illegal_seen), 32'(seen_exp));
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("drain.valid", 32'(out_valid), 0);

    // Backpressure: hold addi for 3 cycles while lui waits at the input
    drive(1, vecs[0].instr, vecs[0].rs, vecs[0].rt, 1, 0);
    tick();
    drive(1, vecs[1].instr, vecs[1].rs, vecs[1].rt, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d.valid", k), 32'(out_valid), 1);
      chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 0);
      chk_out($sformatf("bp%0d", k), vecs[0].e);
    end
    out_ready = 1;
    #1;
    chk("bp.in_ready_release", 32'(in_ready), 1);
    tick();
    chk("bp.next_valid", 32'(out_valid), 1);
    chk_out("bp.next", vecs[1].e);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("bp.no_dup", 32'(out_valid), 0);

    // Flush while holding with a new instruction at the input
    drive(1, vecs[2].instr, vecs[2].rs, vecs[2].rt, 0, 0);
    tick();
    chk("fl.pre_valid", 32'(out_valid), 1);
    drive(1, vecs[6].instr, vecs[6].rs, vecs[6].rt, 0, 1);
    tick();
    chk("fl.valid", 32'(out_valid), 0);
    chk("fl.seen_kept", 32'(illegal_seen), 1);
    drive(1, vecs[5].instr, vecs[5].rs, vecs[5].rt, 1, 0);
    tick();
    chk("fl.after_valid", 32'(out_valid), 1);
    chk_out("fl.after", vecs[5].e);
    drive(0, 0, 0, 0, 1, 0);
    tick();

    // Asynchronous reset while holding an illegal instruction
    drive(1, 32'hFC000000, 0, 0, 0, 0);
    tick();
    chk("ar.pre_valid", 32'(out_valid), 1);
    chk("ar.pre_ill", 32'(out_illegal), 1);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("ar.valid", 32'(out_valid), 0);
    chk("ar.seen", 32'(illegal_seen), 0);
    chk("ar.ill", 32'(out_illegal), 0);
    chk("ar.in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against a cycle-level reference model
    m_vld = 0; m_seen = 0; m_rec = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.valid", 32'(out_valid), 32'(m_vld));
      chk("rnd.seen", 32'(illegal_seen), 32'(m_seen));
      if (m_vld) chk_out("rnd", m_rec);
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
      #1;
      m_rdy = !m_vld || out_ready;
      chk("rnd.in_ready", 32'(in_ready), 32'(m_rdy));
      m_acc = in_valid && m_rdy && !flush;
      d = ref_decode(instr, rs_data, rt_data);
      if (flush) m_vld = 0;
      else if (m_acc) begin
        m_vld = 1; m_rec = d; m_seen = m_seen | d.ill;
      end else if (out_ready) m_vld = 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
